// File: rtl/psad_min_select_if.sv
// ============================================================================
// Module  : psad_min_select_if
// Brief   : Input-beat and result handshake bundle for psad_min_select.
//           best_tie is present only when PSAD_MIN_TIE_DETECT_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface psad_min_select_if #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int PSAD_BIT_DEPTH  = 14,
    parameter int INDEX_WIDTH     = 8
);
    logic                                  psad_in_valid;
    logic                                  psad_in_ready;
    logic [PIXELS_IN_BATCH*PSAD_BIT_DEPTH-1:0] psad_in;
    logic                                  best_valid;
    logic                                  best_ready;
    logic [PSAD_BIT_DEPTH-1:0]             best_sad;
    logic [INDEX_WIDTH-1:0]                best_index;
`ifdef PSAD_MIN_TIE_DETECT_EN
    logic                                  best_tie;

    modport slave (
        input  psad_in_valid, psad_in, best_ready,
        output psad_in_ready, best_valid, best_sad, best_index, best_tie
    );
    modport master (
        output psad_in_valid, psad_in, best_ready,
        input  psad_in_ready, best_valid, best_sad, best_index, best_tie
    );
`else
    modport slave (
        input  psad_in_valid, psad_in, best_ready,
        output psad_in_ready, best_valid, best_sad, best_index
    );
    modport master (
        output psad_in_valid, psad_in, best_ready,
        input  psad_in_ready, best_valid, best_sad, best_index
    );
`endif
endinterface

`default_nettype wire

// File: rtl/psad_min_select.sv
// ============================================================================
// Module  : psad_min_select
// Brief   : Minimum-SAD search over one block of PSAD beats; optional tie
//           flag enabled by PSAD_MIN_TIE_DETECT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module psad_min_select #(
    parameter int PIXELS_IN_BATCH   = 16,
    parameter int PSAD_BIT_DEPTH    = 14,
    parameter int BATCHES_PER_BLOCK = 16,
    parameter int INDEX_WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    psad_min_select_if.slave bus
);
    localparam int LANE_W = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1;
    localparam int BEAT_W = (BATCHES_PER_BLOCK > 1) ? $clog2(BATCHES_PER_BLOCK) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BATCHES_PER_BLOCK - 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]                r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_hold_exit;

    logic [PSAD_BIT_DEPTH-1:0] w_lane_min;
    logic [LANE_W-1:0]         w_lane_idx;

    logic                      r_s1_valid;
    logic [PSAD_BIT_DEPTH-1:0] r_s1_sad;
    logic [LANE_W-1:0]         r_s1_lane;
    logic [BEAT_W-1:0]         r_s1_beat;
    logic [INDEX_WIDTH-1:0]    w_s1_index;

    logic [PSAD_BIT_DEPTH-1:0] r_run_sad;
    logic [INDEX_WIDTH-1:0]    r_run_index;
    logic                      w_first;
    logic                      w_improve;
    logic [PSAD_BIT_DEPTH-1:0] w_merge_sad;
    logic [INDEX_WIDTH-1:0]    w_merge_index;

    logic [PSAD_BIT_DEPTH-1:0] r_best_sad;
    logic [INDEX_WIDTH-1:0]    r_best_index;

    assign w_accept    = bus.psad_in_valid && (r_state == ST_ACCUM);
    assign w_last      = w_accept && (r_beat == LAST_BEAT);
    assign w_hold_exit = (r_state == ST_HOLD) && bus.best_ready;

    assign bus.psad_in_ready = (r_state == ST_ACCUM);
    assign bus.best_valid    = (r_state == ST_HOLD);
    assign bus.best_sad      = r_best_sad;
    assign bus.best_index    = r_best_index;

    // Strict less-than keeps the lowest lane on equal values.
    always_comb begin
        w_lane_min = bus.psad_in[PSAD_BIT_DEPTH-1:0];
        w_lane_idx = '0;
        for (int i = 1; i < PIXELS_IN_BATCH; i++) begin
            if (bus.psad_in[i*PSAD_BIT_DEPTH +: PSAD_BIT_DEPTH] < w_lane_min) begin
                w_lane_min = bus.psad_in[i*PSAD_BIT_DEPTH +: PSAD_BIT_DEPTH];
                w_lane_idx = LANE_W'(i);
            end
        end
    end

    assign w_s1_index = INDEX_WIDTH'(r_s1_beat) * INDEX_WIDTH'(PIXELS_IN_BATCH)
                      + INDEX_WIDTH'(r_s1_lane);

    assign w_first       = (r_s1_beat == '0);
    assign w_improve     = (r_s1_sad < r_run_sad);
    assign w_merge_sad   = (w_first || w_improve) ? r_s1_sad   : r_run_sad;
    assign w_merge_index = (w_first || w_improve) ? w_s1_index : r_run_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_last) r_state <= ST_DRAIN;
                ST_DRAIN: r_state <= ST_HOLD;
                ST_HOLD:  if (bus.best_ready) r_state <= ST_ACCUM;
                default:  r_state <= ST_ACCUM;
            endcase
            if (w_accept) begin
                r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
            end else if (w_hold_exit) begin
                r_beat <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sad     <= '0;
            r_s1_lane    <= '0;
            r_s1_beat    <= '0;
            r_run_sad    <= '0;
            r_run_index  <= '0;
            r_best_sad   <= '0;
            r_best_index <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sad  <= w_lane_min;
                r_s1_lane <= w_lane_idx;
                r_s1_beat <= r_beat;
            end
            if (r_s1_valid) begin
                r_run_sad   <= w_merge_sad;
                r_run_index <= w_merge_index;
            end else if (w_hold_exit) begin
                r_run_sad   <= '0;
                r_run_index <= '0;
            end
            // s1 holds the last beat during DRAIN, so the merge is the final answer.
            if (r_state == ST_DRAIN) begin
                r_best_sad   <= w_merge_sad;
                r_best_index <= w_merge_index;
            end
        end
    end

`ifdef PSAD_MIN_TIE_DETECT_EN
    logic w_lane_tie;
    logic r_s1_tie;
    logic r_run_tie;
    logic w_merge_tie;
    logic r_best_tie;

    always_comb begin
        w_lane_tie = 1'b0;
        for (int i = 0; i < PIXELS_IN_BATCH; i++) begin
            if ((bus.psad_in[i*PSAD_BIT_DEPTH +: PSAD_BIT_DEPTH] == w_lane_min) &&
                (LANE_W'(i) != w_lane_idx)) begin
                w_lane_tie = 1'b1;
            end
        end
    end

    assign w_merge_tie = w_first   ? r_s1_tie :
                         w_improve ? 1'b0     :
                         (r_s1_sad == r_run_sad) ? 1'b1 : r_run_tie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_tie   <= 1'b0;
            r_run_tie  <= 1'b0;
            r_best_tie <= 1'b0;
        end else begin
            if (w_accept)           r_s1_tie  <= w_lane_tie;
            if (r_s1_valid)         r_run_tie <= w_merge_tie;
            else if (w_hold_exit)   r_run_tie <= 1'b0;
            if (r_state == ST_DRAIN) r_best_tie <= w_merge_tie;
        end
    end

    assign bus.best_tie = r_best_tie;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psad_min_select.sv
// ============================================================================
// Module  : tb_psad_min_select
// Brief   : Self-checking bench for psad_min_select against a block-level model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_psad_min_select;
    localparam int P  = 16;
    localparam int D  = 14;
    localparam int B  = 16;
    localparam int IW = 8;
    localparam int W  = P * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    psad_min_select_if #(.PIXELS_IN_BATCH(P), .PSAD_BIT_DEPTH(D), .INDEX_WIDTH(IW)) bus ();

    psad_min_select #(
        .PIXELS_IN_BATCH  (P),
        .PSAD_BIT_DEPTH   (D),
        .BATCHES_PER_BLOCK(B),
        .INDEX_WIDTH      (IW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int blk[B][P];
    int exp_sad;
    int exp_idx;
    bit exp_tie;
    int first_acc;
    int last_acc;

    function automatic logic [W-1:0] pack_beat(input int b);
        logic [W-1:0] v;
        v = '0;
        for (int l = 0; l < P; l++) v[l*D +: D] = D'(blk[b][l]);
        return v;
    endfunction

    // Reference: flat minimum with earliest index; tie follows the per-beat merge rules.
    task automatic model();
        int run;
        int m;
        int cnt;
        exp_sad = blk[0][0];
        exp_idx = 0;
        for (int b = 0; b < B; b++)
            for (int l = 0; l < P; l++)
                if (blk[b][l] < exp_sad) begin
                    exp_sad = blk[b][l];
                    exp_idx = b * P + l;
                end
        exp_idx = exp_idx % (1 << IW);
        run = 0;
        exp_tie = 1'b0;
        for (int b = 0; b < B; b++) begin
            m = blk[b][0];
            for (int l = 1; l < P; l++) if (blk[b][l] < m) m = blk[b][l];
            cnt = 0;
            for (int l = 0; l < P; l++) if (blk[b][l] == m) cnt++;
            if (b == 0) begin
                run = m;
                exp_tie = (cnt >= 2);
            end else if (m < run) begin
                run = m;
                exp_tie = 1'b0;
            end else if (m == run) begin
                exp_tie = 1'b1;
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int b = 0; b < B; b++) for (int l = 0; l < P; l++) blk[b][l] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int b = 0; b < B; b++)
            for (int l = 0; l < P; l++) blk[b][l] = int'($urandom_range(hi, lo));
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_beat(input int b, output int acc_cyc);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        acc_cyc = -1;
        bus.psad_in = pack_beat(b);
        bus.psad_in_valid = 1'b1;
        while (!acc) begin
            if (guard >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_accept_timeout: beat %0d not accepted, required accept within 200 cycles", b);
                break;
            end
            acc = bus.psad_in_ready;
            if (acc) acc_cyc = cyc + 1;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic send_block(input int nbeats);
        int c;
        for (int b = 0; b < nbeats; b++) begin
            send_beat(b, c);
            if (b == 0) first_acc = c;
            last_acc = c;
        end
        bus.psad_in_valid = 1'b0;
    endtask

    task automatic wait_best(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.best_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL best_valid_timeout: best_valid stayed 0, required 1 within 60 cycles");
        end
    endtask

    task automatic consume();
        bus.best_ready = 1'b1;
        @(negedge clk);
        bus.best_ready = 1'b0;
    endtask

    task automatic check_result(input string name);
        n_cmp++;
        if (bus.best_sad !== D'(exp_sad)) begin
            n_bad++;
            $display("FAIL %s best_sad: got %0d required %0d", name, bus.best_sad, exp_sad);
        end
        n_cmp++;
        if (bus.best_index !== IW'(exp_idx)) begin
            n_bad++;
            $display("FAIL %s best_index: got %0d required %0d", name, bus.best_index, exp_idx);
        end
`ifdef PSAD_MIN_TIE_DETECT_EN
        n_cmp++;
        if (bus.best_tie !== exp_tie) begin
            n_bad++;
            $display("FAIL %s best_tie: got %0b required %0b", name, bus.best_tie, exp_tie);
        end
`endif
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.psad_in_ready, bus.best_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_handshake: ready/valid got %b%b required 10", bus.psad_in_ready, bus.best_valid);
        end
        n_cmp++;
        if (bus.best_sad !== '0 || bus.best_index !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: sad/index got %0d/%0d required 0/0", bus.best_sad, bus.best_index);
        end
`ifdef PSAD_MIN_TIE_DETECT_EN
        n_cmp++;
        if (bus.best_tie !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tie: got %0b required 0", bus.best_tie);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        fill_const(0);
        send_block(5);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.psad_in_ready, bus.best_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL midblock_reset_handshake: ready/valid got %b%b required 10", bus.psad_in_ready, bus.best_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fill_rand(100, 16383);
        model();
        send_block(B);
        wait_best(ok);
        check_result("post_reset_block");
        consume();
    endtask

    task automatic test_single_min();
        bit ok;
        fill_const(1000);
        blk[3][7] = 12;
        model();
        send_block(B);
        wait_best(ok);
        n_cmp++;
        if (bus.best_sad !== 14'd12 || bus.best_index !== 8'd55) begin
            n_bad++;
            $display("FAIL single_min: sad/index got %0d/%0d required 12/55", bus.best_sad, bus.best_index);
        end
        check_result("single_min");
        consume();
    endtask

    task automatic test_ties();
        bit ok;
        fill_const(1000);
        blk[0][2] = 0;
        blk[5][9] = 0;
        model();
        send_block(B);
        wait_best(ok);
        check_result("tie_across_beats");
        consume();
        fill_rand(500, 16383);
        blk[0][4]  = 0;
        blk[0][11] = 0;
        model();
        send_block(B);
        wait_best(ok);
        check_result("tie_in_beat");
        consume();
    endtask

    task automatic test_all_max();
        bit ok;
        fill_const(16383);
        model();
        send_block(B);
        wait_best(ok);
        check_result("all_max");
        consume();
    endtask

    task automatic test_backpressure();
        bit ok;
        fill_rand(0, 16383);
        model();
        send_block(B);
        wait_best(ok);
        bus.psad_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.psad_in = {W{1'b0}};
            n_cmp++;
            if ({bus.psad_in_ready, bus.best_valid} !== 2'b01) begin
                n_bad++;
                $display("FAIL hold_handshake cycle %0d: ready/valid got %b%b required 01", i, bus.psad_in_ready, bus.best_valid);
            end
            check_result("hold_stable");
            @(negedge clk);
        end
        bus.psad_in_valid = 1'b0;
        consume();
        n_cmp++;
        if ({bus.psad_in_ready, bus.best_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL hold_release: ready/valid got %b%b required 10", bus.psad_in_ready, bus.best_valid);
        end
        fill_rand(0, 16383);
        model();
        send_block(B);
        wait_best(ok);
        check_result("after_backpressure");
        consume();
    endtask

    task automatic test_throughput();
        bit ok;
        int c0;
        int k;
        bus.best_ready = 1'b1;
        fill_rand(0, 16383);
        model();
        send_block(B);
        c0 = first_acc;
        k  = last_acc;
        n_cmp++;
        if (k - c0 !== B - 1) begin
            n_bad++;
            $display("FAIL back_to_back: beat span got %0d cycles required %0d", k - c0, B - 1);
        end
        n_cmp++;
        if ({bus.psad_in_ready, bus.best_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL drain_cycle: ready/valid got %b%b required 00", bus.psad_in_ready, bus.best_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.best_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL result_latency: best_valid got %0b one edge after drain, required 1", bus.best_valid);
        end
        check_result("throughput_blk1");
        fill_rand(0, 16383);
        model();
        send_block(B);
        n_cmp++;
        if (first_acc - c0 !== B + 2) begin
            n_bad++;
            $display("FAIL block_period: got %0d cycles required %0d", first_acc - c0, B + 2);
        end
        wait_best(ok);
        check_result("throughput_blk2");
        bus.best_ready = 1'b0;
        consume();
    endtask

    task automatic test_random();
        bit ok;
        for (int n = 0; n < 6; n++) begin
            case (n % 3)
                0:       fill_rand(0, 16383);
                1:       fill_rand(0, 7);
                default: begin
                    fill_rand(8000, 16383);
                    blk[$urandom_range(B-1, 0)][$urandom_range(P-1, 0)] = 3;
                    blk[$urandom_range(B-1, 0)][$urandom_range(P-1, 0)] = 3;
                end
            endcase
            model();
            send_block(B);
            wait_best(ok);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            check_result("random_block");
            consume();
        end
    endtask

    initial begin
        bus.psad_in_valid = 1'b0;
        bus.psad_in       = '0;
        bus.best_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_min();
        test_ties();
        test_all_max();
        test_backpressure();
        test_throughput();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psad_min_select.md
# psad_min_select

Consumer of the accumulated partial-SAD batches produced by the motion-estimation PSAD adder stage. Each beat carries PIXELS_IN_BATCH packed PSAD lanes, and BATCHES_PER_BLOCK beats make up one search block. The block scans every candidate in the block and returns the minimum SAD together with its flat candidate index. It uses a valid/ready handshake on both sides, so it sits between the PSAD accumulator array and the motion-vector decision logic.

## Interface
- PIXELS_IN_BATCH, 16, lanes per input beat
- PSAD_BIT_DEPTH, 14, width of one PSAD lane
- BATCHES_PER_BLOCK, 16, beats per search block (must be ≥1)
- INDEX_WIDTH, 8, width of the candidate index; must be ≥ clog2(PIXELS_IN_BATCH*BATCHES_PER_BLOCK)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- psad_in_valid  in  1  input beat valid
- psad_in_ready  out  1  input beat accepted when valid&ready at a rising edge
- psad_in  in  PIXELS_IN_BATCH*PSAD_BIT_DEPTH  packed lanes; lane i = bits [(i+1)*PSAD_BIT_DEPTH-1 : i*PSAD_BIT_DEPTH]
- best_valid  out  1  result valid
- best_ready  in  1  result consumed when valid&ready at a rising edge
- best_sad  out  PSAD_BIT_DEPTH  minimum SAD of the block
- best_index  out  INDEX_WIDTH  beat_number*PIXELS_IN_BATCH + lane of the minimum
- best_tie  out  1  present only with PSAD_MIN_TIE_DETECT_EN

## Operation
- **FSM states**
  - ACCUM: psad_in_ready=1. Stays in ACCUM until the beat counter reaches BATCHES_PER_BLOCK-1 and a beat is accepted; it then moves to DRAIN.
  - DRAIN: psad_in_ready=0. Lasts exactly one cycle, then moves to HOLD.
  - HOLD: psad_in_ready=0, best_valid=1. On best_ready it returns to ACCUM and clears the beat counter and running best.
- **Stage 1 (on accept)**
  - An unsigned compare tree over the lanes produces the lane minimum and its lane number.
  - Ties resolve to the lowest lane.
  - The result is registered in s1, with s1_valid set, and tagged with the beat number.
- **Stage 2 (each edge with s1_valid)**
  - Beat 0 loads the running best unconditionally.
  - Later beats replace the running best only if strictly less, so the earliest index wins ties.
  - s1_valid clears when no new beat is accepted.
- **Output load:** the DRAIN edge loads best_sad/best_index from the final merge (running best combined with s1 for the last beat). Outputs hold stable through HOLD.
- **Beat counter:** counts 0..BATCHES_PER_BLOCK-1 and wraps to 0 on the last accept.
- **Arithmetic:** PSAD values are unsigned, with no saturation. Index arithmetic is unsigned and truncated to INDEX_WIDTH.
- **Reset:** async reset mid-block discards all partial state, leaves state ACCUM, and clears the counter and s1_valid.

## Timing
- Reset values: psad_in_ready=1, best_valid=0, best_sad=0, best_index=0, best_tie=0.
- Non-last beats are accepted back-to-back, one per cycle.
- Last beat accepted at edge k: DRAIN occupies cycle k..k+1, and best_valid is high from edge k+1.
- Minimum block period is BATCHES_PER_BLOCK+1 cycles plus the HOLD dwell.
- best_ready asserted while best_valid=1: HOLD exits on that edge, and psad_in_ready is high in the next cycle.
- best_ready while not in HOLD has no effect.
- psad_in_valid while not in ACCUM is ignored; data is not consumed.

## Configuration
- PSAD_MIN_TIE_DETECT_EN defined:
  - The best_tie port exists.
  - Stage 1 flags an in-beat tie when two lanes equal the lane minimum.
  - Stage 2 sets tie on an equal merge, clears it on a strict improvement, and loads it on beat 0 from the stage-1 flag.
  - best_tie is valid with best_valid.
- Undefined: no best_tie port and no tie logic.

## Test plan
- **Reset default:** assert rst_n=0 mid-block after 5 beats, release, then feed a full block → the result covers only the post-reset block; after reset psad_in_ready=1 and best_valid=0.
- **Single minimum:** defaults, every lane=1000 except beat 3 lane 7=12 → best_sad=12, best_index=55, best_tie=0.
- **Ties:** lane 2 of beat 0 and lane 9 of beat 5 both =0 → best_index=2, best_tie=1. Two lanes =0 in beat 0 at lanes 4 and 11 → best_index=4, best_tie=1.
- **All-max:** every lane=16383 → best_sad=16383, best_index=0.
- **Backpressure:** hold best_ready=0 for 10 cycles after best_valid → psad_in_ready=0 and outputs stable throughout. Then pulse best_ready → psad_in_ready=1 the next cycle; the next block is independent of the previous one.
- **Throughput:** continuous valid with best_ready=1 → last-beat-to-best_valid latency is 1 edge, block period 17 cycles plus HOLD.
